// File: rtl/exec_csr_mul_unit.sv
// exec_csr_mul_unit
//
// Execute-stage helper for the RV32 pipeline. It combines the CSR file used by
// CSR instructions with the multi-cycle multiplier used by the MUL family.
//
// Parameters
//   LATENCY  multiplier cycles from start to done in fixed mode (1..32)
//   BOOTH    0 = fixed-latency product, 1 = iterative radix-2 Booth (33 cycles)
//
// Ports
//   clk, reset_n      clock, asynchronous active-low reset
//   go                multiply request, held by execute until done
//   sign0 / sign1     operand r / operand m is signed
//   m, r              multiplicand / multiplier
//   done              one-cycle pulse, result valid during it
//   result            64-bit product, held until the next operation completes
//   inc_instret       one instruction retired this cycle
//   addr, write       CSR address and write op (00 none, 01 write, 10 set, 11 clear)
//   data_in           CSR write data
//   data_out          combinational CSR read data (pre-write, pre-increment)

module exec_csr_mul_unit #(
  parameter int LATENCY = 4,
  parameter int BOOTH   = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        go,
  input  logic        sign0,
  input  logic        sign1,
  input  logic [31:0] m,
  input  logic [31:0] r,
  output logic        done,
  output logic [63:0] result,
  input  logic        inc_instret,
  input  logic [11:0] addr,
  input  logic [1:0]  write,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  localparam int         MUL_CYCLES = (BOOTH != 0) ? 33 : LATENCY;
  localparam logic [5:0] CNT_LOAD   = 6'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  mul_state_e  state;
  mul_state_e  state_next;
  logic [5:0]  cnt;
  logic        start;
  logic        last_step;
  logic [32:0] m_ext;
  logic [32:0] r_ext;
  logic [63:0] product;

  // Operands widened to 33 bits so that signed and unsigned forms share one
  // signed datapath; the 66-bit signed product truncated to 64 bits covers
  // MUL, MULH, MULHSU and MULHU.
  assign m_ext     = {sign1 & m[31], m};
  assign r_ext     = {sign0 & r[31], r};
  assign start     = (state == IDLE) && go;
  assign last_step = (state == BUSY) && (cnt == 6'd0);
  assign done      = (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // DONE always returns to IDLE, so a held go restarts one cycle later with
  // whatever operands are present then.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go) state_next = BUSY;
      BUSY:    if (cnt == 6'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Loaded with cycles-1: BUSY lasts MUL_CYCLES cycles, so DONE follows the
  // edge MUL_CYCLES after the start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 6'd0;
    end else if (start) begin
      cnt <= CNT_LOAD;
    end else if ((state == BUSY) && (cnt != 6'd0)) begin
      cnt <= cnt - 6'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result <= 64'd0;
    end else if (last_step) begin
      result <= product;
    end
  end

  generate
    if (BOOTH != 0) begin : g_booth
      // Accumulator carries two guard bits beyond the 33-bit operand so that
      // adding or subtracting a full-scale multiplicand never overflows.
      logic [34:0] mcand;
      logic [34:0] acc;
      logic [34:0] sum;
      logic [34:0] acc_next;
      logic [32:0] mplier;
      logic [32:0] mplier_next;
      logic        q_m1;

      always_comb begin
        sum = acc;
        case ({mplier[0], q_m1})
          2'b01:   sum = acc + mcand;
          2'b10:   sum = acc - mcand;
          default: sum = acc;
        endcase
      end

      assign acc_next    = {sum[34], sum[34:1]};
      assign mplier_next = {sum[0], mplier[32:1]};
      // The final step's shifted value is the product; it is taken straight
      // from the step logic on the last BUSY edge.
      assign product     = {acc_next[30:0], mplier_next};

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          mcand  <= 35'd0;
          acc    <= 35'd0;
          mplier <= 33'd0;
          q_m1   <= 1'b0;
        end else if (start) begin
          mcand  <= {{2{m_ext[32]}}, m_ext};
          acc    <= 35'd0;
          mplier <= r_ext;
          q_m1   <= 1'b0;
        end else if (state == BUSY) begin
          acc    <= acc_next;
          mplier <= mplier_next;
          q_m1   <= mplier[0];
        end
      end
    end else begin : g_fixed
      logic [32:0] m_q;
      logic [32:0] r_q;
      logic [63:0] m_wide;
      logic [63:0] r_wide;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          m_q <= 33'd0;
          r_q <= 33'd0;
        end else if (start) begin
          m_q <= m_ext;
          r_q <= r_ext;
        end
      end

      // Sign-extending to 64 bits lets a plain 64x64 multiply produce the
      // low 64 bits of the signed 33x33 product.
      assign m_wide  = {{31{m_q[32]}}, m_q};
      assign r_wide  = {{31{r_q[32]}}, r_q};
      assign product = m_wide * r_wide;
    end
  endgenerate

  logic [63:0] cycle_cnt;
  logic [63:0] instret_cnt;
  logic [31:0] mscratch;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt   <= 64'd0;
      instret_cnt <= 64'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (inc_instret) begin
        instret_cnt <= instret_cnt + 64'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mscratch <= 32'd0;
    end else if (addr == 12'h340) begin
      case (write)
        2'b01:   mscratch <= data_in;
        2'b10:   mscratch <= mscratch | data_in;
        2'b11:   mscratch <= mscratch & ~data_in;
        default: mscratch <= mscratch;
      endcase
    end
  end

  // Time CSRs alias the cycle counter; user and machine counter addresses
  // read the same registers.
  always_comb begin
    data_out = 32'd0;
    case (addr)
      12'hC00, 12'hB00, 12'hC01: data_out = cycle_cnt[31:0];
      12'hC80, 12'hB80, 12'hC81: data_out = cycle_cnt[63:32];
      12'hC02, 12'hB02:          data_out = instret_cnt[31:0];
      12'hC82, 12'hB82:          data_out = instret_cnt[63:32];
      12'h340:                   data_out = mscratch;
      default:                   data_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_exec_csr_mul_unit.sv
// Testbench for exec_csr_mul_unit: a fixed-latency instance and a Booth
// instance share clock, reset and CSR inputs. A behavioural model tracks
// counters, mscratch and expected multiplier completions by edge number.

module tb_exec_csr_mul_unit;

  localparam int FAST_LAT = 4;

  logic        clk;
  logic        reset_n;
  logic        inc_instret;
  logic [11:0] addr;
  logic [1:0]  write;
  logic [31:0] data_in;

  logic        go_f, sign0_f, sign1_f, done_f;
  logic [31:0] m_f, r_f, data_out_f;
  logic [63:0] result_f;

  logic        go_b, sign0_b, sign1_b, done_b;
  logic [31:0] m_b, r_b, data_out_b;
  logic [63:0] result_b;

  int checks;
  int failures;

  exec_csr_mul_unit #(.LATENCY(FAST_LAT), .BOOTH(0)) dut_fast (
    .clk(clk), .reset_n(reset_n), .go(go_f), .sign0(sign0_f), .sign1(sign1_f),
    .m(m_f), .r(r_f), .done(done_f), .result(result_f),
    .inc_instret(inc_instret), .addr(addr), .write(write),
    .data_in(data_in), .data_out(data_out_f)
  );

  exec_csr_mul_unit #(.LATENCY(FAST_LAT), .BOOTH(1)) dut_booth (
    .clk(clk), .reset_n(reset_n), .go(go_b), .sign0(sign0_b), .sign1(sign1_b),
    .m(m_b), .r(r_b), .done(done_b), .result(result_b),
    .inc_instret(inc_instret), .addr(addr), .write(write),
    .data_in(data_in), .data_out(data_out_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  longint      edge_no;
  longint      exp_done_edge [2];
  longint      free_at [2];
  logic [63:0] pend_res [2];
  logic [63:0] exp_res [2];
  longint      lat [2];
  logic [63:0] cyc_m;
  logic [63:0] inst_m;
  logic [31:0] msc_m;

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic sa, input logic sb);
    logic [63:0] x, y;
    x = sa ? {{32{a[31]}}, a} : {32'd0, a};
    y = sb ? {{32{b[31]}}, b} : {32'd0, b};
    return x * y;
  endfunction

  function automatic logic [31:0] csr_ref(input logic [11:0] a);
    case (a)
      12'hC00, 12'hB00, 12'hC01: return cyc_m[31:0];
      12'hC80, 12'hB80, 12'hC81: return cyc_m[63:32];
      12'hC02, 12'hB02:          return inst_m[31:0];
      12'hC82, 12'hB82:          return inst_m[63:32];
      12'h340:                   return msc_m;
      default:                   return 32'd0;
    endcase
  endfunction

  task automatic model_clear();
    for (int u = 0; u < 2; u++) begin
      exp_done_edge[u] = -1;
      free_at[u]       = 0;
      pend_res[u]      = 64'd0;
      exp_res[u]       = 64'd0;
    end
    cyc_m  = 64'd0;
    inst_m = 64'd0;
    msc_m  = 32'd0;
  endtask

  // A start at edge e completes at edge e+L and the unit can next accept go
  // at edge e+L+2 (the DONE cycle is followed by one IDLE cycle).
  task automatic model_mul(input int u, input logic g, input logic [31:0] a,
                           input logic [31:0] b, input logic sa, input logic sb);
    if (edge_no == exp_done_edge[u]) exp_res[u] = pend_res[u];
    if (g && edge_no >= free_at[u]) begin
      pend_res[u]      = ref_prod(a, b, sa, sb);
      exp_done_edge[u] = edge_no + lat[u];
      free_at[u]       = edge_no + lat[u] + 2;
    end
  endtask

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Model process: advances on every clock edge out of reset.
  initial begin
    lat[0]  = FAST_LAT;
    lat[1]  = 33;
    edge_no = 0;
    model_clear();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        model_clear();
      end else begin
        edge_no++;
        if (addr == 12'h340) begin
          case (write)
            2'b01:   msc_m = data_in;
            2'b10:   msc_m = msc_m | data_in;
            2'b11:   msc_m = msc_m & ~data_in;
            default: msc_m = msc_m;
          endcase
        end
        cyc_m = cyc_m + 64'd1;
        if (inc_instret) inst_m = inst_m + 64'd1;
        model_mul(0, go_f, m_f, r_f, sign1_f, sign0_f);
        model_mul(1, go_b, m_b, r_b, sign1_b, sign0_b);
      end
    end
  end

  // Compare process: every falling edge, all outputs of both instances.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("fast_done",   {63'd0, done_f}, {63'd0, edge_no == exp_done_edge[0]});
      checkOutput("fast_result", result_f, exp_res[0]);
      checkOutput("booth_done",  {63'd0, done_b}, {63'd0, edge_no == exp_done_edge[1]});
      checkOutput("booth_result", result_b, exp_res[1]);
      checkOutput("fast_csr",    {32'd0, data_out_f}, {32'd0, csr_ref(addr)});
      checkOutput("booth_csr",   {32'd0, data_out_b}, {32'd0, csr_ref(addr)});
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // One call = the inputs seen by exactly one rising edge.
  task automatic applyStimulus(input logic [11:0] a, input logic [1:0] w,
                               input logic [31:0] d, input logic inc);
    @(posedge clk);
    #2;
    addr        = a;
    write       = w;
    data_in     = d;
    inc_instret = inc;
  endtask

  task automatic csr_expect(input logic [11:0] a, input logic [1:0] w, input logic [31:0] d,
                            input logic [31:0] exp, input string nm);
    applyStimulus(a, w, d, 1'b0);
    @(negedge clk);
    checkOutput(nm, {32'd0, data_out_f}, {32'd0, exp});
  endtask

  task automatic run_fast(input logic [31:0] mm, input logic [31:0] rr, input logic s1,
                          input logic s0, input logic [63:0] expv, input string nm);
    int seen;
    logic [63:0] res;
    seen = -1;
    res  = 64'd0;
    @(posedge clk);
    #2;
    go_f = 1'b1; m_f = mm; r_f = rr; sign1_f = s1; sign0_f = s0;
    @(posedge clk);
    for (int j = 0; j <= 60; j++) begin
      @(negedge clk);
      if (done_f) begin
        seen = j;
        res  = result_f;
        break;
      end
    end
    #1 go_f = 1'b0;
    checkOutput({nm, "_latency"}, 64'(seen), 64'(FAST_LAT));
    checkOutput({nm, "_result"}, res, expv);
  endtask

  task automatic run_booth(input logic [31:0] mm, input logic [31:0] rr, input logic s1,
                           input logic s0, input logic [63:0] expv, input string nm);
    int seen;
    logic [63:0] res;
    seen = -1;
    res  = 64'd0;
    @(posedge clk);
    #2;
    go_b = 1'b1; m_b = mm; r_b = rr; sign1_b = s1; sign0_b = s0;
    @(posedge clk);
    for (int j = 0; j <= 80; j++) begin
      @(negedge clk);
      if (done_b) begin
        seen = j;
        res  = result_b;
        break;
      end
    end
    #1 go_b = 1'b0;
    checkOutput({nm, "_latency"}, 64'(seen), 64'd33);
    checkOutput({nm, "_result"}, res, expv);
  endtask

  logic [11:0] read_list [12];

  initial begin
    int first_at, second_at, pulses, booth_pulses;
    logic [63:0] res1, res2;
    logic [31:0] ra, rb;
    logic        sa, sb;
    int          combo;

    checks = 0; failures = 0;
    reset_n = 1'b1;
    inc_instret = 1'b0; addr = 12'h000; write = 2'b00; data_in = 32'd0;
    go_f = 1'b0; sign0_f = 1'b0; sign1_f = 1'b0; m_f = 32'd0; r_f = 32'd0;
    go_b = 1'b0; sign0_b = 1'b0; sign1_b = 1'b0; m_b = 32'd0; r_b = 32'd0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_done",   {63'd0, done_f}, 64'd0);
    checkOutput("reset_result", result_f, 64'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;

    // Idle 5 edges, then counters and scratch
    repeat (4) applyStimulus(12'h000, 2'b00, 32'd0, 1'b0);
    csr_expect(12'hC00, 2'b00, 32'd0, 32'd5, "cycle_lo_after5");
    csr_expect(12'hC80, 2'b00, 32'd0, 32'd0, "cycle_hi");
    csr_expect(12'h340, 2'b00, 32'd0, 32'd0, "mscratch_reset");
    csr_expect(12'h123, 2'b00, 32'd0, 32'd0, "unmapped_read");

    // mscratch write / set / clear; each read shows the previous edge's result
    applyStimulus(12'h340, 2'b01, 32'hF0F0_00FF, 1'b0);
    csr_expect(12'h340, 2'b10, 32'h0000_FF00, 32'hF0F0_00FF, "mscratch_write");
    csr_expect(12'h340, 2'b11, 32'h0000_00F0, 32'hF0F0_FFFF, "mscratch_set");
    csr_expect(12'h340, 2'b00, 32'd0,         32'hF0F0_FF0F, "mscratch_clear");

    // Writes to a counter and to an unmapped address have no effect
    applyStimulus(12'hC00, 2'b01, 32'h0000_0000, 1'b0);
    applyStimulus(12'h123, 2'b01, 32'hFFFF_FFFF, 1'b0);
    csr_expect(12'h123, 2'b00, 32'd0, 32'd0, "unmapped_write_ignored");
    csr_expect(12'h340, 2'b00, 32'd0, 32'hF0F0_FF0F, "mscratch_kept");

    // instret: 3 pulses over 10 cycles
    for (int i = 0; i < 10; i++)
      applyStimulus(12'hC02, 2'b00, 32'd0, (i == 1 || i == 4 || i == 7));
    csr_expect(12'hC02, 2'b00, 32'd0, 32'd3, "instret_lo");
    csr_expect(12'hC82, 2'b00, 32'd0, 32'd0, "instret_hi");

    // Walk the full map; the compare process checks each read against the model
    read_list = '{12'hC00, 12'hB00, 12'hC01, 12'hC80, 12'hB80, 12'hC81,
                  12'hC02, 12'hB02, 12'hC82, 12'hB82, 12'h340, 12'h7FF};
    foreach (read_list[i]) applyStimulus(read_list[i], 2'b00, 32'd0, 1'b0);
    applyStimulus(12'h000, 2'b00, 32'd0, 1'b0);

    // Fixed-latency multiplier
    run_fast(32'hFFFF_FFFF, 32'd2, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, "mul_ss");
    run_fast(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 64'h0000_0001_FFFF_FFFE, "mul_uu");
    run_fast(32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, "mul_su");

    // go held across two operations: pulse-to-pulse period is L+2 cycles
    // (DONE, then one IDLE gap cycle that samples the new operands).
    first_at = -1; second_at = -1; pulses = 0; res1 = 64'd0; res2 = 64'd0;
    @(posedge clk);
    #2;
    go_f = 1'b1; m_f = 32'd7; r_f = 32'd6; sign1_f = 1'b1; sign0_f = 1'b1;
    @(posedge clk);
    for (int j = 0; j <= 40 && pulses < 2; j++) begin
      @(negedge clk);
      if (done_f) begin
        if (pulses == 0) begin
          first_at = j;
          res1 = result_f;
          #1;
          m_f = 32'h8000_0000; r_f = 32'h8000_0000;
        end else begin
          second_at = j;
          res2 = result_f;
          #1 go_f = 1'b0;
        end
        pulses++;
      end
    end
    go_f = 1'b0;
    checkOutput("b2b_first_latency", 64'(first_at), 64'(FAST_LAT));
    checkOutput("b2b_first_result", res1, 64'd42);
    checkOutput("b2b_second_at", 64'(second_at), 64'(2 * FAST_LAT + 2));
    checkOutput("b2b_second_result", res2, 64'h4000_0000_0000_0000);
    repeat (3) @(posedge clk);

    // Booth instance: literal corners then random vectors
    run_booth(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'd1, "booth_m1m1");
    run_booth(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001, "booth_uu_max");
    run_booth(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 64'hC000_0000_0000_0000, "booth_su_min");
    for (int k = 0; k < 6; k++) begin
      ra = $urandom;
      rb = $urandom;
      combo = $urandom_range(0, 2);
      sa = (combo != 2);
      sb = (combo == 0);
      run_booth(ra, rb, sa, sb, ref_prod(ra, rb, sa, sb), $sformatf("booth_rand%0d", k));
    end

    // Reset during BUSY aborts the operation without a done pulse
    @(posedge clk);
    #2;
    go_b = 1'b1; m_b = 32'd123; r_b = 32'd456; sign1_b = 1'b0; sign0_b = 1'b0;
    @(posedge clk);
    go_b = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    booth_pulses = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (done_b) booth_pulses++;
    end
    checkOutput("booth_abort_no_done", 64'(booth_pulses), 64'd0);
    checkOutput("booth_abort_result", result_b, 64'd0);
    run_booth(32'd1000, 32'hFFFF_FFFD, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_F448, "booth_after_reset");

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
